gray_mem_arb: RTL and testbench
===============================

GRAY_MEM_ARB -- requirements
Module: gray_mem_arb

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports r0_req / r1_req  input  1  read request from requester 0 (LBP engine) / requester 1.
REQ-004 SHALL have ports r0_addr / r1_addr  input  14  gray-image pixel address, held stable while reqX=1.
REQ-005 SHALL have ports r0_lock / r1_lock  input  1  keep ownership for the next request (window burst).
REQ-006 SHALL have ports r0_gnt / r1_gnt  output  1  request accepted this cycle (combinational from state and req).
REQ-007 SHALL have ports r0_rvalid / r1_rvalid  output  1  read data valid for that requester.
REQ-008 SHALL have ports r0_rdata / r1_rdata  output  8  read data, equal to mem_rdata when rvalid=1, else 0.
REQ-009 SHALL have ports mem_en  output  1  and mem_addr  output  14  registered read command to single-port gray memory.
REQ-010 SHALL have port mem_rdata  input  8  memory data, valid exactly one cycle after mem_en.
REQ-011 SHALL have port busy  output  1  high while any read is in flight or a lock is held.

Function
REQ-012 SHALL grant at most one requester per cycle; reqX=1 and gntX=1 in cycle N is one accepted read.
REQ-013 SHALL drive mem_en=1 and mem_addr = granted address in cycle N+1; mem_en=0 in all other cycles.
REQ-014 SHALL assert rX_rvalid for the granted requester in cycle N+2 with rX_rdata = mem_rdata; sustained throughput one read per cycle.
REQ-015 SHALL keep an FSM with states IDLE, OWN0, OWN1; IDLE arbitrates round-robin, OWNx grants only requester x.
REQ-016 SHALL, in IDLE with both requests, grant the requester not served last; after reset requester 0 wins first.
REQ-017 SHALL, in IDLE with one request, grant it immediately regardless of round-robin pointer.
REQ-018 SHALL update the last-served pointer on every grant.
REQ-019 SHALL, with no requests, grant nothing and leave pointer and state unchanged.
REQ-020 SHALL never issue a grant to a requester whose req is 0, including in OWNx.
REQ-021 SHALL keep the rvalid tag pipeline independent of FSM state so in-flight reads always complete.

Reset
REQ-022 SHALL, on reset, force state=IDLE, pointer=1, lock counter=0, mem_en=0, mem_addr=0, both gnt=0, both rvalid=0, both rdata=0, busy=0.
REQ-023 SHALL discard in-flight reads when reset is asserted mid-operation: no rvalid in any cycle after the reset edge.

Configuration
REQ-024 SHALL, with GRAY_ARB_LOCK_EN defined, enter OWNx when requester x is granted with rX_lock=1, and return to IDLE on the first grant with rX_lock=0.
REQ-025 SHALL, with GRAY_ARB_LOCK_EN defined, force OWNx to IDLE after LOCK_MAX=9 consecutive locked grants, and give the other requester priority if it is requesting.
REQ-026 SHALL, with GRAY_ARB_LOCK_EN defined, stay in OWNx while reqx=0 and rX_lock=1 (stall), subject to the LOCK_MAX count of grants only.
REQ-027 SHALL, without GRAY_ARB_LOCK_EN, ignore rX_lock, never leave IDLE, and omit the lock counter.

Structure
REQ-028 SHALL place ADDR_W=14, DATA_W=8, LOCK_MAX=9 and the FSM state enum in shared package gray_arb_pkg.
REQ-029 SHALL implement the 2-way round-robin pick as sub-module gray_arb_rr (inputs: two reqs, pointer; output: one-hot grant).

Verification
REQ-030 SHALL cover: both req, r0_addr=129, r1_addr=5, no lock -> grants alternate 0,1,0,1; mem_addr 129,5,129,5 from cycle N+1; rvalid alternates from N+2.
REQ-031 SHALL cover (LOCK_EN): r0 locked for 9 reads, addresses 0,1,2,128,129,130,256,257,258, r1 requesting -> r1 gets no grant until all 9 are granted, then r1 granted next cycle.
REQ-032 SHALL cover (LOCK_EN): r0 lock held 12 reads while r1 requests -> forced release after 9th grant, r1 granted in cycle 10.
REQ-033 SHALL cover: only r1 requesting at addr 16254 right after reset -> r1_gnt same cycle, mem_addr=16254 at N+1, r1_rvalid at N+2 with memory byte.
REQ-034 SHALL cover: reset asserted one cycle after a grant -> mem_en, rvalid, busy all 0 afterwards; next grant goes to r0 when both request.
REQ-035 SHALL cover (no LOCK_EN): r0_lock=1 constantly, both requesting -> strict alternation identical to REQ-030.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// Shared types and sizing for the gray-image memory read arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gray_arb_pkg;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int LOCK_MAX = 9;
  localparam int LOCK_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/gray_arb_rr.sv
// Two-way round-robin pick: one-hot grant from two requests and a last-served pointer.
// Latency: combinational.
// Backpressure: none; a requester that is not picked simply sees no grant.
// Ports: req0/req1 requests, last_served (1 = requester 1 served last), gnt one-hot {r1,r0}.
module gray_arb_rr (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_served,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      // Contention: favour whoever was not served last.
      gnt = last_served ? 2'b01 : 2'b10;
    end else begin
      gnt = {req1, req0};
    end
  end

endmodule

// File: rtl/gray_mem_arb.sv
// Arbitrates two pixel readers onto one single-port gray memory (round-robin, optional lock bursts).
// Latency: grant same cycle as req, mem_en/mem_addr at N+1, rvalid/rdata at N+2; one read per cycle.
// Backpressure: a requester holds req/addr until it sees gnt; in-flight reads always complete.
// Ports: rX_req/rX_addr/rX_lock in, rX_gnt/rX_rvalid/rX_rdata out, mem_en/mem_addr/mem_rdata to memory, busy.
// Build option: define GRAY_ARB_LOCK_EN to enable lock-held ownership (OWN0/OWN1) with a LOCK_MAX cap.
module gray_mem_arb
  import gray_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_lock,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_lock,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t state, state_nxt;
  logic       last_served, last_served_nxt;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic       s1_id;

  gray_arb_rr u_rr (
    .req0        (r0_req),
    .req1        (r1_req),
    .last_served (last_served),
    .gnt         (rr_gnt)
  );

`ifdef GRAY_ARB_LOCK_EN
  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_MAX - 1);
  logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt;
`else
  logic lock_unused;
  assign lock_unused = r0_lock ^ r1_lock;
`endif

  always_comb begin
    gnt             = 2'b00;
    state_nxt       = state;
    last_served_nxt = last_served;
`ifdef GRAY_ARB_LOCK_EN
    lock_cnt_nxt    = lock_cnt;
`endif
    // Grants are suppressed during reset so nothing is accepted that would be discarded.
    if (!reset) begin
      unique case (state)
        ST_OWN0: gnt = {1'b0, r0_req};
        ST_OWN1: gnt = {r1_req, 1'b0};
        default: gnt = rr_gnt;
      endcase
    end
    if (gnt != 2'b00) last_served_nxt = gnt[1];

`ifdef GRAY_ARB_LOCK_EN
    unique case (state)
      ST_OWN0: begin
        if (gnt[0]) begin
          // Release on an unlocked grant or when the burst cap is hit; last_served=0
          // then hands priority to requester 1.
          if (!r0_lock || lock_cnt == LOCK_LAST) begin
            state_nxt    = ST_IDLE;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt + 1'b1;
          end
        end else if (!r0_lock) begin
          state_nxt    = ST_IDLE;
          lock_cnt_nxt = '0;
        end
      end
      ST_OWN1: begin
        if (gnt[1]) begin
          if (!r1_lock || lock_cnt == LOCK_LAST) begin
            state_nxt    = ST_IDLE;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt + 1'b1;
          end
        end else if (!r1_lock) begin
          state_nxt    = ST_IDLE;
          lock_cnt_nxt = '0;
        end
      end
      default: begin
        if (gnt[0] && r0_lock) begin
          state_nxt    = ST_OWN0;
          lock_cnt_nxt = LOCK_CNT_W'(1);
        end else if (gnt[1] && r1_lock) begin
          state_nxt    = ST_OWN1;
          lock_cnt_nxt = LOCK_CNT_W'(1);
        end
      end
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_served <= 1'b1;
`ifdef GRAY_ARB_LOCK_EN
      lock_cnt    <= '0;
`endif
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
`ifdef GRAY_ARB_LOCK_EN
      lock_cnt    <= lock_cnt_nxt;
`endif
    end
  end

  // Read pipeline: tag travels with the command so returns never depend on FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      s1_id     <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      mem_en    <= |gnt;
      s1_id     <= gnt[1];
      if (|gnt) mem_addr <= gnt[1] ? r1_addr : r0_addr;
      r0_rvalid <= mem_en && !s1_id;
      r1_rvalid <= mem_en &&  s1_id;
    end
  end

  assign r0_gnt   = gnt[0];
  assign r1_gnt   = gnt[1];
  assign r0_rdata = r0_rvalid ? mem_rdata : '0;
  assign r1_rdata = r1_rvalid ? mem_rdata : '0;
  assign busy     = mem_en || r0_rvalid || r1_rvalid || (state != ST_IDLE);

endmodule

// File: tb/tb_gray_mem_arb.sv
// Directed self-checking bench for gray_mem_arb.
// Memory model returns addr[7:0]^8'h5A one cycle after mem_en.
module tb_gray_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r1_req, r0_lock, r1_lock;
  logic [13:0] r0_addr, r1_addr;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [7:0]  r0_rdata, r1_rdata;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  gray_mem_arb dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_lock(r0_lock),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_lock(r1_lock),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem_en ? (mem_addr[7:0] ^ 8'h5A) : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef GRAY_ARB_LOCK_EN
  logic [13:0] lk_addr [9] = '{14'd0, 14'd1, 14'd2, 14'd128, 14'd129, 14'd130,
                               14'd256, 14'd257, 14'd258};
`endif

  initial begin
    logic alt_lock;
    // ---------------- reset, with requests asserted ----------------
    reset = 1'b1;
    r0_req = 1'b1; r1_req = 1'b1; r0_lock = 1'b0; r1_lock = 1'b0;
    r0_addr = 14'd0; r1_addr = 14'd0;
    #1;
    chk("rst_g0", r0_gnt, 0);
    chk("rst_g1", r1_gnt, 0);
    tick();
    tick();
    chk("rst_g0b", r0_gnt, 0);
    chk("rst_memen", mem_en, 0);
    reset = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    #1;
    chk("rst_memaddr", mem_addr, 0);
    chk("rst_rv0", r0_rvalid, 0);
    chk("rst_rv1", r1_rvalid, 0);
    chk("rst_rd0", r0_rdata, 0);
    chk("rst_rd1", r1_rdata, 0);
    chk("rst_busy", busy, 0);

    // ---------------- single requester r1 right after reset ----------------
    r1_req = 1'b1; r1_addr = 14'd16254;
    #1;
    chk("one_g1", r1_gnt, 1);
    chk("one_g0", r0_gnt, 0);
    tick();
    r1_req = 1'b0;
    #1;
    chk("one_memen", mem_en, 1);
    chk("one_memaddr", mem_addr, 16254);
    chk("one_busy", busy, 1);
    tick();
    chk("one_rv1", r1_rvalid, 1);
    chk("one_rv0", r0_rvalid, 0);
    chk("one_rd1", r1_rdata, 8'h24);
    tick();
    chk("one_memen_off", mem_en, 0);
    chk("one_rv1_off", r1_rvalid, 0);

    // ---------------- alternation (lock ignored when feature is off) ----------------
`ifdef GRAY_ARB_LOCK_EN
    alt_lock = 1'b0;
`else
    alt_lock = 1'b1;
`endif
    r0_addr = 14'd129; r1_addr = 14'd5;
    r0_req = 1'b1; r1_req = 1'b1; r0_lock = alt_lock; r1_lock = alt_lock;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin r0_req = 1'b0; r1_req = 1'b0; end
      #1;
      if (k < 4) begin
        chk("alt_g0", r0_gnt, (k % 2) == 0);
        chk("alt_g1", r1_gnt, (k % 2) == 1);
      end
      if (k >= 1 && k < 5) begin
        chk("alt_memen", mem_en, 1);
        chk("alt_memaddr", mem_addr, ((k - 1) % 2 == 0) ? 129 : 5);
      end
      if (k >= 2) begin
        chk("alt_rv0", r0_rvalid, (k % 2) == 0);
        chk("alt_rv1", r1_rvalid, (k % 2) == 1);
        chk("alt_rd0", r0_rdata, ((k % 2) == 0) ? 8'hDB : 8'h00);
        chk("alt_rd1", r1_rdata, ((k % 2) == 1) ? 8'h5F : 8'h00);
      end
      tick();
    end
    r0_lock = 1'b0; r1_lock = 1'b0;
    tick();

`ifdef GRAY_ARB_LOCK_EN
    // ---------------- 9-read locked burst, r1 waiting ----------------
    r0_req = 1'b1; r1_req = 1'b1; r0_lock = 1'b1; r1_lock = 1'b0;
    for (int k = 0; k < 11; k++) begin
      r0_addr = (k < 9) ? lk_addr[k] : 14'd0;
      if (k == 9)  begin r0_req = 1'b0; r0_lock = 1'b0; end
      if (k == 10) r1_req = 1'b0;
      #1;
      if (k < 9) begin
        chk("lk9_g0", r0_gnt, 1);
        chk("lk9_g1", r1_gnt, 0);
      end
      if (k == 9) begin
        chk("lk9_g1_rel", r1_gnt, 1);
        chk("lk9_g0_rel", r0_gnt, 0);
      end
      if (k >= 1 && k <= 9) chk("lk9_memaddr", mem_addr, lk_addr[k-1]);
      if (k == 5) chk("lk9_busy", busy, 1);
      if (k == 10) chk("lk9_memaddr_r1", mem_addr, 5);
      tick();
    end
    tick();

    // ---------------- lock held for 12: forced release after 9 ----------------
    r0_req = 1'b1; r1_req = 1'b1; r0_lock = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("lk12_g0", r0_gnt, (k < 9) || (k >= 10));
      chk("lk12_g1", r1_gnt, k == 9);
      tick();
    end
    r0_req = 1'b0; r1_req = 1'b0; r0_lock = 1'b0;
    tick();
    tick();
    tick();
    chk("lk12_idle_busy", busy, 0);
`endif

    // ---------------- reset one cycle after a grant ----------------
    r0_addr = 14'd129; r1_addr = 14'd5;
    r0_req = 1'b1; r1_req = 1'b1;
    #1;
    chk("mid_gnt_any", r0_gnt | r1_gnt, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_g0", r0_gnt, 0);
    chk("mid_rst_g1", r1_gnt, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_memen", mem_en, 0);
    chk("mid_rv0", r0_rvalid, 0);
    chk("mid_rv1", r1_rvalid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_next_g0", r0_gnt, 1);
    chk("mid_next_g1", r1_gnt, 0);
    tick();
    r0_req = 1'b0; r1_req = 1'b0;
    #1;
    chk("mid_memen2", mem_en, 1);
    chk("mid_memaddr2", mem_addr, 129);
    chk("mid_rv1_late", r1_rvalid, 0);
    tick();
    chk("mid_rv0_new", r0_rvalid, 1);
    chk("mid_rd0_new", r0_rdata, 8'hDB);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
